mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit between the EX/MEM register and the MEM/WB register (wb_control + data regs).

---
 rtl/mem_pkg.sv | 31 +++
 rtl/lsu_align.sv | 38 +++
 rtl/mem_stage_lsu.sv | 127 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
// Holds the FSM state enum, the funct3 access-size codes and the byte-strobe size mask.
package mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } lsu_state_t;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LD  = 3'b011;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_LWU = 3'b110;

   // Unshifted byte strobes for the access size; bit 2 (unsigned) does not change the size.
   function automatic logic [7:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the LSU: positions store data/strobes within the
// memory word and extracts plus sign/zero-extends the addressed field of a load response.
module lsu_align
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]        funct3,
   input  logic [2:0]        offset,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   resp_data,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN/8-1:0] wstrb,
   output logic [XLEN-1:0]   load_ext
);

   localparam int STRB_W = XLEN / 8;

   logic [XLEN-1:0] field;

   assign wdata = store_data << {offset, 3'b000};
   assign wstrb = STRB_W'(size_mask(funct3)) << offset;
   assign field = resp_data >> {offset, 3'b000};

   always_comb begin
      load_ext = field;
      case (funct3)
         FUNCT3_LB:  load_ext = {{(XLEN-8){field[7]}}, field[7:0]};
         FUNCT3_LH:  load_ext = {{(XLEN-16){field[15]}}, field[15:0]};
         FUNCT3_LW:  load_ext = {{(XLEN-32){field[31]}}, field[31:0]};
         FUNCT3_LBU: load_ext = {{(XLEN-8){1'b0}}, field[7:0]};
         FUNCT3_LHU: load_ext = {{(XLEN-16){1'b0}}, field[15:0]};
         FUNCT3_LWU: load_ext = {{(XLEN-32){1'b0}}, field[31:0]};
         default:    load_ext = field;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory request per load/store, stalls the
// pipeline while it is outstanding and hands the extended load result to MEM/WB.
module mem_stage_lsu
   import mem_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   store_data,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   output logic              reg_write_out,
   output logic              mem_to_reg_out,
   output logic [XLEN-1:0]   load_data,
   output logic              misaligned,
   output logic              mem_stall,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_req_we,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic [XLEN-1:0]   dmem_req_wdata,
   output logic [XLEN/8-1:0] dmem_req_wstrb,
   input  logic              dmem_resp_valid,
   input  logic [XLEN-1:0]   dmem_resp_data
);

   lsu_state_t      state, state_next;
   logic            size_bad;
   logic            mem_op;
   logic            load_en;
   logic [XLEN-1:0] load_ext;

   always_comb begin
      size_bad = 1'b0;
      case (funct3[1:0])
         2'b01:   size_bad = addr[0];
         2'b10:   size_bad = |addr[1:0];
         2'b11:   size_bad = |addr[2:0];
         default: size_bad = 1'b0;
      endcase
   end

   assign misaligned     = ex_valid & (mem_read | mem_write) & size_bad;
   assign mem_op         = ex_valid & (mem_read | mem_write) & ~misaligned & ~flush;
   assign reg_write_out  = reg_write_in & ex_valid & ~misaligned & ~flush;
   assign mem_to_reg_out = mem_to_reg_in;

   // Request fields follow the EX/MEM register directly; the stall keeps them stable.
   assign dmem_req_we   = mem_write;
   assign dmem_req_addr = {addr[ADDR_W-1:3], 3'b000};

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (funct3),
      .offset     (addr[2:0]),
      .store_data (store_data),
      .resp_data  (dmem_resp_data),
      .wdata      (dmem_req_wdata),
      .wstrb      (dmem_req_wstrb),
      .load_ext   (load_ext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         load_data <= '0;
      end else begin
         state <= state_next;
         if (load_en) load_data <= load_ext;
      end
   end

   // A response arriving together with a flush in WAIT is the one DRAIN would wait for,
   // so it is dropped here and the FSM returns straight to IDLE.
   always_comb begin
      state_next     = state;
      mem_stall      = 1'b0;
      dmem_req_valid = 1'b0;
      load_en        = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_op) begin
               mem_stall  = 1'b1;
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            mem_stall = 1'b1;
            if (flush) begin
               state_next = S_IDLE;
            end else begin
               dmem_req_valid = 1'b1;
               if (dmem_req_ready) state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_stall = 1'b1;
            if (dmem_resp_valid) begin
               if (flush) begin
                  state_next = S_IDLE;
               end else begin
                  load_en    = 1'b1;
                  state_next = S_DONE;
               end
            end else if (flush) begin
               state_next = S_DRAIN;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         S_DRAIN: begin
            mem_stall = 1'b1;
            if (dmem_resp_valid) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: aligned loads/stores, misalignment,
// request backpressure, flush-to-drain and reset in the middle of an access.
module tb_mem_stage_lsu;
   import mem_pkg::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        ex_valid;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] store_data;
   logic        reg_write_in;
   logic        mem_to_reg_in;
   logic        reg_write_out;
   logic        mem_to_reg_out;
   logic [63:0] load_data;
   logic        misaligned;
   logic        mem_stall;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_req_we;
   logic [63:0] dmem_req_addr;
   logic [63:0] dmem_req_wdata;
   logic [7:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [63:0] dmem_resp_data;

   int total = 0;
   int bad   = 0;

   mem_stage_lsu dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .ex_valid        (ex_valid),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .funct3          (funct3),
      .addr            (addr),
      .store_data      (store_data),
      .reg_write_in    (reg_write_in),
      .mem_to_reg_in   (mem_to_reg_in),
      .reg_write_out   (reg_write_out),
      .mem_to_reg_out  (mem_to_reg_out),
      .load_data       (load_data),
      .misaligned      (misaligned),
      .mem_stall       (mem_stall),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_req_we     (dmem_req_we),
      .dmem_req_addr   (dmem_req_addr),
      .dmem_req_wdata  (dmem_req_wdata),
      .dmem_req_wstrb  (dmem_req_wstrb),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_data  (dmem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ev, input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [63:0] a, input logic [63:0] sd, input logic rw, input logic m2r);
      ex_valid      = ev;
      mem_read      = rd;
      mem_write     = wr;
      funct3        = f3;
      addr          = a;
      store_data    = sd;
      reg_write_in  = rw;
      mem_to_reg_in = m2r;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Load with immediate ready and response: IDLE, REQ, WAIT, DONE.
   task automatic runLoad(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] exp_addr, input logic [63:0] resp, input logic [63:0] exp_data);
      int stalls;
      stalls = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, f3, a, 64'h0, 1'b1, 1'b0);
      dmem_req_ready  = 1'b1;
      dmem_resp_valid = 1'b0;
      #1;
      if (mem_stall) stalls++;
      checkOutput({tag, "_idle_req_valid"}, 64'(dmem_req_valid), 64'd0);
      cyc();
      if (mem_stall) stalls++;
      checkOutput({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
      checkOutput({tag, "_req_addr"}, dmem_req_addr, exp_addr);
      checkOutput({tag, "_req_we"}, 64'(dmem_req_we), 64'd0);
      cyc();
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = resp;
      #1;
      if (mem_stall) stalls++;
      cyc();
      dmem_resp_valid = 1'b0;
      #1;
      if (mem_stall) stalls++;
      checkOutput({tag, "_load_data"}, load_data, exp_data);
      checkOutput({tag, "_stall_cycles"}, 64'(stalls), 64'd3);
      checkOutput({tag, "_reg_write_out"}, 64'(reg_write_out), 64'd1);
      cyc();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);
      #1;
      checkOutput({tag, "_back_idle_stall"}, 64'(mem_stall), 64'd0);
   endtask

   initial begin
      reset           = 1'b1;
      flush           = 1'b0;
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = 64'h0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      checkOutput("rst_stall", 64'(mem_stall), 64'd0);
      checkOutput("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      checkOutput("rst_load_data", load_data, 64'h0);
      cyc();

      $display("[TB] loads with immediate handshake");
      runLoad("lb",  FUNCT3_LB,  64'h1003, 64'h1000, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
      runLoad("lh",  FUNCT3_LH,  64'h6002, 64'h6000, 64'h00000000_80010000, 64'hFFFFFFFF_FFFF8001);
      runLoad("ld",  FUNCT3_LD,  64'h5000, 64'h5000, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
      runLoad("lbu", FUNCT3_LBU, 64'h9005, 64'h9000, 64'h00009A00_00000000, 64'h00000000_0000009A);
      runLoad("lw",  FUNCT3_LW,  64'hA004, 64'hA000, 64'h80000001_00000000, 64'hFFFFFFFF_80000001);

      $display("[TB] store halfword");
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 1'b0, 1'b1);
      dmem_req_ready = 1'b1;
      #1;
      checkOutput("sh_idle_stall", 64'(mem_stall), 64'd1);
      cyc();
      checkOutput("sh_req_valid", 64'(dmem_req_valid), 64'd1);
      checkOutput("sh_wstrb", 64'(dmem_req_wstrb), 64'hC0);
      checkOutput("sh_wdata", dmem_req_wdata, 64'hBEEF0000_00000000);
      checkOutput("sh_we", 64'(dmem_req_we), 64'd1);
      checkOutput("sh_addr", dmem_req_addr, 64'h2000);
      cyc();
      dmem_resp_valid = 1'b1;
      cyc();
      dmem_resp_valid = 1'b0;
      #1;
      checkOutput("sh_done_stall", 64'(mem_stall), 64'd0);
      cyc();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);

      $display("[TB] misaligned word load");
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 1'b1, 1'b0);
      #1;
      checkOutput("lw_mis_flag", 64'(misaligned), 64'd1);
      checkOutput("lw_mis_reg_write", 64'(reg_write_out), 64'd0);
      checkOutput("lw_mis_stall", 64'(mem_stall), 64'd0);
      cyc();
      checkOutput("lw_mis_req_valid", 64'(dmem_req_valid), 64'd0);
      checkOutput("lw_mis_stall_next", 64'(mem_stall), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b011, 64'h3002, 64'h0, 1'b1, 1'b1);
      #1;
      checkOutput("alu_op_not_mis", 64'(misaligned), 64'd0);
      checkOutput("alu_op_reg_write", 64'(reg_write_out), 64'd1);
      checkOutput("alu_op_mem_to_reg", 64'(mem_to_reg_out), 64'd1);
      cyc();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);

      $display("[TB] backpressure then unsigned word load");
      applyStimulus(1'b1, 1'b1, 1'b0, FUNCT3_LWU, 64'h4004, 64'h0, 1'b1, 1'b0);
      dmem_req_ready = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("lwu_hold_valid_%0d", i), 64'(dmem_req_valid), 64'd1);
         checkOutput($sformatf("lwu_hold_addr_%0d", i), dmem_req_addr, 64'h4000);
         checkOutput($sformatf("lwu_hold_stall_%0d", i), 64'(mem_stall), 64'd1);
         cyc();
      end
      checkOutput("lwu_wstrb", 64'(dmem_req_wstrb), 64'hF0);
      dmem_req_ready = 1'b1;
      cyc();
      checkOutput("lwu_wait_req_valid", 64'(dmem_req_valid), 64'd0);
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 64'hFFFFFFFF_00000000;
      cyc();
      dmem_resp_valid = 1'b0;
      #1;
      checkOutput("lwu_load_data", load_data, 64'h00000000_FFFFFFFF);
      checkOutput("lwu_done_stall", 64'(mem_stall), 64'd0);
      cyc();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);

      $display("[TB] flush in WAIT drains the response");
      applyStimulus(1'b1, 1'b1, 1'b0, FUNCT3_LB, 64'h7000, 64'h0, 1'b1, 1'b0);
      cyc();
      cyc();
      flush = 1'b1;
      #1;
      checkOutput("flush_wait_reg_write", 64'(reg_write_out), 64'd0);
      checkOutput("flush_wait_stall", 64'(mem_stall), 64'd1);
      cyc();
      flush = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("drain_stall_%0d", i), 64'(mem_stall), 64'd1);
         checkOutput($sformatf("drain_reg_write_%0d", i), 64'(reg_write_out), 64'd0);
         cyc();
      end
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 64'h55;
      #1;
      checkOutput("drain_resp_stall", 64'(mem_stall), 64'd1);
      cyc();
      dmem_resp_valid = 1'b0;
      #1;
      checkOutput("drain_exit_stall", 64'(mem_stall), 64'd0);
      checkOutput("drain_discarded", load_data, 64'h00000000_FFFFFFFF);

      $display("[TB] flush in REQ cancels the request");
      applyStimulus(1'b1, 1'b1, 1'b0, FUNCT3_LB, 64'h7100, 64'h0, 1'b1, 1'b0);
      dmem_req_ready = 1'b0;
      cyc();
      flush = 1'b1;
      #1;
      checkOutput("flush_req_valid", 64'(dmem_req_valid), 64'd0);
      cyc();
      flush = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);
      #1;
      checkOutput("flush_req_idle_stall", 64'(mem_stall), 64'd0);
      dmem_req_ready = 1'b1;
      cyc();

      $display("[TB] reset in WAIT");
      applyStimulus(1'b1, 1'b1, 1'b0, FUNCT3_LD, 64'h8000, 64'h0, 1'b1, 1'b0);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b0, 1'b0);
      #1;
      checkOutput("rst_wait_req_valid", 64'(dmem_req_valid), 64'd0);
      checkOutput("rst_wait_stall", 64'(mem_stall), 64'd0);
      checkOutput("rst_wait_load_data", load_data, 64'h0);
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 64'hDEADBEEF_CAFEF00D;
      cyc();
      dmem_resp_valid = 1'b0;
      #1;
      checkOutput("late_resp_load_data", load_data, 64'h0);
      checkOutput("late_resp_stall", 64'(mem_stall), 64'd0);
      checkOutput("late_resp_req_valid", 64'(dmem_req_valid), 64'd0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
